alu_v2_core: RTL

Parametrised second-generation ALU core for the ALU project. It replaces the fixed-width single-issue ALU_DESIGN datapath behind the same alu_if-style pin set. Additions over the previous core:
- operands may arrive in separate cycles, with a parametrised timeout;
- multiplies run through a parametrised-latency pipeline;
- RES_VALID and BUSY outputs.

---
 rtl/alu_v2_pkg.sv | 74 +++++++
 rtl/alu_v2_mul.sv | 52 +++++
 rtl/alu_v2_core.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_v2_pkg.sv
// Shared types for the second-generation ALU core: command codes, FSM states, flag bundle.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package alu_v2_pkg;

    typedef enum logic [3:0] {
        A_ADD     = 4'd0,
        A_SUB     = 4'd1,
        A_ADD_CIN = 4'd2,
        A_SUB_CIN = 4'd3,
        A_INC_A   = 4'd4,
        A_DEC_A   = 4'd5,
        A_INC_B   = 4'd6,
        A_DEC_B   = 4'd7,
        A_CMP     = 4'd8,
        A_MUL_INC = 4'd9,
        A_MUL_SHL = 4'd10
    } arith_cmd_e;

    typedef enum logic [3:0] {
        L_AND     = 4'd0,
        L_NAND    = 4'd1,
        L_OR      = 4'd2,
        L_NOR     = 4'd3,
        L_XOR     = 4'd4,
        L_XNOR    = 4'd5,
        L_NOT_A   = 4'd6,
        L_NOT_B   = 4'd7,
        L_SHR1_A  = 4'd8,
        L_SHL1_A  = 4'd9,
        L_SHR1_B  = 4'd10,
        L_SHL1_B  = 4'd11,
        L_ROL_A_B = 4'd12,
        L_ROR_A_B = 4'd13
    } logic_cmd_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_OP = 2'd1,
        MUL     = 2'd2
    } state_t;

    // Flag bundle in output order; one field per status pin.
    typedef struct packed {
        logic cout;
        logic oflow;
        logic err;
        logic g;
        logic e;
        logic l;
    } flags_t;

    // True when the command consumes only OPA.
    function automatic logic a_only(input logic mode, input logic [3:0] cmd);
        if (mode) return (cmd == A_INC_A) || (cmd == A_DEC_A);
        else      return (cmd == L_NOT_A) || (cmd == L_SHR1_A) || (cmd == L_SHL1_A);
    endfunction

    // True when the command consumes only OPB.
    function automatic logic b_only(input logic mode, input logic [3:0] cmd);
        if (mode) return (cmd == A_INC_B) || (cmd == A_DEC_B);
        else      return (cmd == L_NOT_B) || (cmd == L_SHR1_B) || (cmd == L_SHL1_B);
    endfunction

    // Undefined codes fall through to "needs both", so they wait like any two-operand op.
    function automatic logic needs_a(input logic mode, input logic [3:0] cmd);
        return !b_only(mode, cmd);
    endfunction

    function automatic logic needs_b(input logic mode, input logic [3:0] cmd);
        return !a_only(mode, cmd);
    endfunction

endpackage

// File: rtl/alu_v2_mul.sv
// Pipelined multiplier: MUL_LAT-1 register stages; the core's result register is the final stage.
// Latency: MUL_LAT-1 cycles to out_vld (combinational pass-through when MUL_LAT=1).
// Backpressure: none; ce low freezes every stage, RST clears all stages.
module alu_v2_mul #(
    parameter int DW      = 8,
    parameter int MUL_LAT = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ce,
    input  logic              in_vld,
    input  logic [DW:0]       op_a,
    input  logic [DW:0]       op_b,
    output logic              out_vld,
    output logic [2*DW-1:0]   out_prod
);

    logic [2*DW-1:0] prod;

    // Product is kept modulo 2^(2*DW) to match the result width.
    assign prod = (2*DW)'(op_a) * (2*DW)'(op_b);

    generate
        if (MUL_LAT == 1) begin : g_comb
            assign out_vld  = in_vld;
            assign out_prod = prod;
        end else begin : g_pipe
            localparam int ST = MUL_LAT - 1;
            logic [2*DW-1:0] prod_q [ST];
            logic [ST-1:0]   vld_q;

            // Shift product and valid token down the pipe while enabled.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    vld_q <= '0;
                    for (int i = 0; i < ST; i++) prod_q[i] <= '0;
                end else if (ce) begin
                    vld_q[0]  <= in_vld;
                    prod_q[0] <= prod;
                    for (int i = 1; i < ST; i++) begin
                        vld_q[i]  <= vld_q[i-1];
                        prod_q[i] <= prod_q[i-1];
                    end
                end
            end

            assign out_vld  = vld_q[ST-1];
            assign out_prod = prod_q[ST-1];
        end
    endgenerate

endmodule

// File: rtl/alu_v2_core.sv
// ALU core with split-operand capture, operand timeout and pipelined multiply.
// Latency: 1 cycle single ops, MUL_LAT cycles multiply, +1 per CE-low cycle.
// Backpressure: none; inputs other than the missing INP_VALID bit are ignored while BUSY.
module alu_v2_core
    import alu_v2_pkg::*;
#(
    parameter int DW      = 8,
    parameter int CW      = 4,
    parameter int MUL_LAT = 3,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CE,
    input  logic              MODE,
    input  logic [CW-1:0]     CMD,
    input  logic [1:0]        INP_VALID,
    input  logic [DW-1:0]     OPA,
    input  logic [DW-1:0]     OPB,
    input  logic              CIN,
    output logic [2*DW-1:0]   RES,
    output logic              COUT,
    output logic              OFLOW,
    output logic              ERR,
    output logic              G,
    output logic              E,
    output logic              L,
    output logic              RES_VALID,
    output logic              BUSY
);

    localparam int LG       = $clog2(DW);
    localparam int CNT_W    = $clog2(TIMEOUT + 1);
    localparam bit MUL_PIPE = (MUL_LAT > 1);

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic            mode_q;
    logic [CW-1:0]   cmd_q;
    logic [DW-1:0]   opnd_q;
    logic            have_a_q;
    flags_t          fl_q;

    logic            eff_mode;
    logic [CW-1:0]   eff_cmd;
    logic [DW-1:0]   eff_a, eff_b;
    logic [3:0]      cmd_lo;
    logic            cmd_hi;

    logic [DW:0]     add_s, addc_s, sub_d, subc_d, inc_a, dec_a, inc_b, dec_b;
    logic [2*DW-1:0] rol_w, ror_w;
    logic            rot_err;
    logic [DW-1:0]   lres;
    logic [2*DW-1:0] alu_res;
    flags_t          alu_fl;

    logic            is_mul, need_a, need_b;
    logic [DW:0]     mul_a, mul_b;
    logic            mul_vld;
    logic [2*DW-1:0] mul_prod;

    logic            idle_in, have_req, arrive, launch, go_mul;
    logic            op_err, to_wait, tmo, mul_done, fire;
    logic [2*DW-1:0] sel_res;
    flags_t          sel_fl;

    // While waiting, command and the held operand come from the latch; the arriving one from the bus.
    always_comb begin
        eff_mode = MODE;
        eff_cmd  = CMD;
        eff_a    = OPA;
        eff_b    = OPB;
        if (state == WAIT_OP) begin
            eff_mode = mode_q;
            eff_cmd  = cmd_q;
            if (have_a_q) eff_a = opnd_q;
            else          eff_b = opnd_q;
        end
    end

    assign cmd_lo  = eff_cmd[3:0];
    assign cmd_hi  = |(eff_cmd >> 4);

    assign add_s   = {1'b0, eff_a} + {1'b0, eff_b};
    assign addc_s  = add_s + (DW+1)'(CIN);
    assign sub_d   = {1'b0, eff_a} - {1'b0, eff_b};
    assign subc_d  = sub_d - (DW+1)'(CIN);
    assign inc_a   = {1'b0, eff_a} + (DW+1)'(1);
    assign dec_a   = {1'b0, eff_a} - (DW+1)'(1);
    assign inc_b   = {1'b0, eff_b} + (DW+1)'(1);
    assign dec_b   = {1'b0, eff_b} - (DW+1)'(1);
    assign rol_w   = {eff_a, eff_a} << eff_b[LG-1:0];
    assign ror_w   = {eff_a, eff_a} >> eff_b[LG-1:0];
    assign rot_err = |(eff_b >> LG);

    // Single-cycle datapath: result and only the flags this command produces.
    always_comb begin
        alu_res = '0;
        alu_fl  = '0;
        lres    = '0;
        if (cmd_hi) begin
            alu_fl.err = 1'b1;
        end else if (eff_mode) begin
            case (cmd_lo)
                A_ADD:     begin alu_res = (2*DW)'(add_s);  alu_fl.cout = add_s[DW];  end
                A_ADD_CIN: begin alu_res = (2*DW)'(addc_s); alu_fl.cout = addc_s[DW]; end
                A_INC_A:   begin alu_res = (2*DW)'(inc_a);  alu_fl.cout = inc_a[DW];  end
                A_INC_B:   begin alu_res = (2*DW)'(inc_b);  alu_fl.cout = inc_b[DW];  end
                A_SUB:     begin alu_res = (2*DW)'(sub_d[DW-1:0]);  alu_fl.oflow = sub_d[DW];  end
                A_SUB_CIN: begin alu_res = (2*DW)'(subc_d[DW-1:0]); alu_fl.oflow = subc_d[DW]; end
                A_DEC_A:   begin alu_res = (2*DW)'(dec_a[DW-1:0]);  alu_fl.oflow = dec_a[DW];  end
                A_DEC_B:   begin alu_res = (2*DW)'(dec_b[DW-1:0]);  alu_fl.oflow = dec_b[DW];  end
                A_CMP: begin
                    alu_fl.g = (eff_a > eff_b);
                    alu_fl.e = (eff_a == eff_b);
                    alu_fl.l = (eff_a < eff_b);
                end
                A_MUL_INC, A_MUL_SHL: ;
                default:   alu_fl.err = 1'b1;
            endcase
        end else begin
            case (cmd_lo)
                L_AND:     lres = eff_a & eff_b;
                L_NAND:    lres = ~(eff_a & eff_b);
                L_OR:      lres = eff_a | eff_b;
                L_NOR:     lres = ~(eff_a | eff_b);
                L_XOR:     lres = eff_a ^ eff_b;
                L_XNOR:    lres = ~(eff_a ^ eff_b);
                L_NOT_A:   lres = ~eff_a;
                L_NOT_B:   lres = ~eff_b;
                L_SHR1_A:  lres = eff_a >> 1;
                L_SHL1_A:  lres = eff_a << 1;
                L_SHR1_B:  lres = eff_b >> 1;
                L_SHL1_B:  lres = eff_b << 1;
                L_ROL_A_B: begin lres = rol_w[2*DW-1:DW]; alu_fl.err = rot_err; end
                L_ROR_A_B: begin lres = ror_w[DW-1:0];    alu_fl.err = rot_err; end
                default:   alu_fl.err = 1'b1;
            endcase
            alu_res = (2*DW)'(lres);
        end
    end

    assign is_mul = eff_mode && !cmd_hi && ((cmd_lo == A_MUL_INC) || (cmd_lo == A_MUL_SHL));
    assign need_a = cmd_hi || needs_a(eff_mode, cmd_lo);
    assign need_b = cmd_hi || needs_b(eff_mode, cmd_lo);
    assign mul_a  = (cmd_lo == A_MUL_INC) ? inc_a : {eff_a, 1'b0};
    assign mul_b  = (cmd_lo == A_MUL_INC) ? inc_b : {1'b0, eff_b};

    alu_v2_mul #(.DW(DW), .MUL_LAT(MUL_LAT)) u_mul (
        .CLK      (CLK),
        .RST      (RST),
        .ce       (CE),
        .in_vld   (launch && is_mul),
        .op_a     (mul_a),
        .op_b     (mul_b),
        .out_vld  (mul_vld),
        .out_prod (mul_prod)
    );

    // Control decode for the current cycle.
    assign idle_in  = (state == IDLE) && (INP_VALID != 2'b00);
    assign have_req = (!need_a || INP_VALID[0]) && (!need_b || INP_VALID[1]);
    assign arrive   = have_a_q ? INP_VALID[1] : INP_VALID[0];
    assign launch   = (idle_in && have_req) || ((state == WAIT_OP) && arrive);
    assign go_mul   = launch && is_mul && MUL_PIPE;
    assign op_err   = idle_in && !have_req && !(need_a && need_b);
    assign to_wait  = idle_in && !have_req && need_a && need_b;
    assign tmo      = (state == WAIT_OP) && !arrive && (cnt == CNT_W'(TIMEOUT - 1));
    assign mul_done = (state == MUL) && mul_vld;
    assign fire     = (launch && !go_mul) || op_err || tmo || mul_done;

    // Pick what the output registers capture on a completing cycle.
    always_comb begin
        sel_res = alu_res;
        sel_fl  = alu_fl;
        if (op_err || tmo) begin
            sel_res    = '0;
            sel_fl     = '0;
            sel_fl.err = 1'b1;
        end else if (mul_done || is_mul) begin
            sel_res = mul_prod;
            sel_fl  = '0;
        end
    end

    // FSM plus registered outputs; CE low holds everything including RES_VALID.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            mode_q    <= 1'b0;
            cmd_q     <= '0;
            opnd_q    <= '0;
            have_a_q  <= 1'b0;
            RES       <= '0;
            fl_q      <= '0;
            RES_VALID <= 1'b0;
        end else if (CE) begin
            RES_VALID <= fire;
            if (fire) begin
                RES  <= sel_res;
                fl_q <= sel_fl;
            end
            case (state)
                IDLE: begin
                    if (to_wait) begin
                        state    <= WAIT_OP;
                        cnt      <= '0;
                        mode_q   <= eff_mode;
                        cmd_q    <= eff_cmd;
                        have_a_q <= INP_VALID[0];
                        opnd_q   <= INP_VALID[0] ? OPA : OPB;
                    end else if (go_mul) begin
                        state <= MUL;
                    end
                end
                WAIT_OP: begin
                    if (go_mul)              state <= MUL;
                    else if (launch || tmo)  state <= IDLE;
                    else                     cnt   <= cnt + CNT_W'(1);
                end
                MUL: begin
                    if (mul_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign COUT  = fl_q.cout;
    assign OFLOW = fl_q.oflow;
    assign ERR   = fl_q.err;
    assign G     = fl_q.g;
    assign E     = fl_q.e;
    assign L     = fl_q.l;
    assign BUSY  = (state != IDLE);

endmodule
